// File: rtl/jelly2_ether_rx_frame_ctl.sv
// rtl/jelly2_ether_rx_frame_ctl.sv - GMII RX frame sequencer: preamble strip, FCS checker drive, FCS strip, status
module jelly2_ether_rx_frame_ctl #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int PREAMBLE_MIN  = 1,
    parameter int FCS_TIMEOUT   = 7,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     reset_n,
    input  logic                     clk,
    input  logic                     cke,
    input  logic [7:0]               s_rx_data,
    input  logic                     s_rx_last,
    input  logic                     s_rx_valid,
    output logic                     fcs_crc_start,
    output logic                     fcs_last,
    output logic [7:0]               fcs_data,
    output logic                     fcs_valid,
    input  logic                     fcs_ok,
    input  logic                     fcs_ng,
    output logic [7:0]               m_frame_data,
    output logic                     m_frame_last,
    output logic                     m_frame_valid,
    output logic                     m_status_valid,
    output logic                     m_status_ok,
    output logic [3:0]               m_status_err,
    output logic [COUNTER_WIDTH-1:0] good_count,
    output logic [COUNTER_WIDTH-1:0] bad_count
);

    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_PAY, ST_WAIT_FCS, ST_DROP} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               pre_cnt_q, pre_cnt_d;
    logic [15:0]              len_q, len_d;
    logic [7:0]               tmo_q, tmo_d;
    logic                     pend_q, pend_d;
    logic [3:0][7:0]          dl_q, dl_d;
    logic [2:0]               dl_cnt_q, dl_cnt_d;
    logic                     crc_start_q, crc_start_d;
    logic                     fcs_last_q, fcs_last_d;
    logic [7:0]               fcs_data_q, fcs_data_d;
    logic                     fcs_valid_q, fcs_valid_d;
    logic [7:0]               frm_data_q, frm_data_d;
    logic                     frm_last_q, frm_last_d;
    logic                     frm_valid_q, frm_valid_d;
    logic                     st_valid_q, st_valid_d;
    logic                     st_ok_q, st_ok_d;
    logic [3:0]               st_err_q, st_err_d;
    logic [COUNTER_WIDTH-1:0] good_q, good_d;
    logic [COUNTER_WIDTH-1:0] bad_q, bad_d;
    logic [3:0]               err_w;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        len_d       = len_q;
        tmo_d       = tmo_q;
        pend_d      = pend_q;
        dl_d        = dl_q;
        dl_cnt_d    = dl_cnt_q;
        crc_start_d = 1'b0;
        fcs_last_d  = 1'b0;
        fcs_data_d  = fcs_data_q;
        fcs_valid_d = 1'b0;
        frm_data_d  = frm_data_q;
        frm_last_d  = 1'b0;
        frm_valid_d = 1'b0;
        st_valid_d  = 1'b0;
        st_ok_d     = st_ok_q;
        st_err_d    = st_err_q;
        good_d      = good_q;
        bad_d       = bad_q;
        err_w       = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (s_rx_valid && !s_rx_last) begin
                    if (s_rx_data == 8'h55) begin
                        state_d   = ST_PRE;
                        pre_cnt_d = 8'd1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PRE: begin
                if (s_rx_valid) begin
                    if (s_rx_last) begin
                        state_d = ST_IDLE;
                    end else if (s_rx_data == 8'h55) begin
                        if (pre_cnt_q != 8'hff) pre_cnt_d = pre_cnt_q + 8'd1;
                    end else if (s_rx_data == 8'hd5 && pre_cnt_q >= 8'(PREAMBLE_MIN)) begin
                        state_d  = ST_PAY;
                        len_d    = 16'd0;
                        dl_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PAY: begin
                if (s_rx_valid) begin
                    fcs_valid_d = 1'b1;
                    fcs_data_d  = s_rx_data;
                    crc_start_d = (len_q == 16'd0);
                    fcs_last_d  = s_rx_last;
                    if (len_q != 16'hffff) len_d = len_q + 16'd1;
                    // The last four bytes held in the line are the FCS and never leave it.
                    if (dl_cnt_q == 3'd4) begin
                        frm_valid_d = 1'b1;
                        frm_data_d  = dl_q[3];
                        frm_last_d  = s_rx_last;
                    end else begin
                        dl_cnt_d = dl_cnt_q + 3'd1;
                    end
                    dl_d = {dl_q[2:0], s_rx_data};
                    if (s_rx_last) begin
                        state_d  = ST_WAIT_FCS;
                        tmo_d    = 8'd0;
                        pend_d   = 1'b0;
                        dl_cnt_d = 3'd0;
                    end
                end
            end
            ST_WAIT_FCS: begin
                // pend tracks a new burst that began while the verdict was outstanding.
                if (s_rx_valid) pend_d = !s_rx_last;
                if (fcs_ok || fcs_ng || tmo_q == 8'(FCS_TIMEOUT)) begin
                    err_w = {!(fcs_ok || fcs_ng),
                             len_q > 16'(MAX_FRAME_LEN),
                             len_q < 16'(MIN_FRAME_LEN),
                             fcs_ng};
                    st_valid_d = 1'b1;
                    st_err_d   = err_w;
                    st_ok_d    = (err_w == 4'b0000);
                    if (err_w == 4'b0000) begin
                        if (!(&good_q)) good_d = good_q + COUNTER_WIDTH'(1);
                    end else begin
                        if (!(&bad_q)) bad_d = bad_q + COUNTER_WIDTH'(1);
                    end
                    state_d = pend_d ? ST_DROP : ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DROP: begin
                if (s_rx_valid && s_rx_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pre_cnt_q   <= 8'd0;
            len_q       <= 16'd0;
            tmo_q       <= 8'd0;
            pend_q      <= 1'b0;
            dl_q        <= '0;
            dl_cnt_q    <= 3'd0;
            crc_start_q <= 1'b0;
            fcs_last_q  <= 1'b0;
            fcs_data_q  <= 8'd0;
            fcs_valid_q <= 1'b0;
            frm_data_q  <= 8'd0;
            frm_last_q  <= 1'b0;
            frm_valid_q <= 1'b0;
            st_valid_q  <= 1'b0;
            st_ok_q     <= 1'b0;
            st_err_q    <= 4'd0;
            good_q      <= '0;
            bad_q       <= '0;
        end else if (cke) begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            len_q       <= len_d;
            tmo_q       <= tmo_d;
            pend_q      <= pend_d;
            dl_q        <= dl_d;
            dl_cnt_q    <= dl_cnt_d;
            crc_start_q <= crc_start_d;
            fcs_last_q  <= fcs_last_d;
            fcs_data_q  <= fcs_data_d;
            fcs_valid_q <= fcs_valid_d;
            frm_data_q  <= frm_data_d;
            frm_last_q  <= frm_last_d;
            frm_valid_q <= frm_valid_d;
            st_valid_q  <= st_valid_d;
            st_ok_q     <= st_ok_d;
            st_err_q    <= st_err_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
        end
    end

    assign fcs_crc_start  = crc_start_q;
    assign fcs_last       = fcs_last_q;
    assign fcs_data       = fcs_data_q;
    assign fcs_valid      = fcs_valid_q;
    assign m_frame_data   = frm_data_q;
    assign m_frame_last   = frm_last_q;
    assign m_frame_valid  = frm_valid_q;
    assign m_status_valid = st_valid_q;
    assign m_status_ok    = st_ok_q;
    assign m_status_err   = st_err_q;
    assign good_count     = good_q;
    assign bad_count      = bad_q;

endmodule
